eth_tx_arb: RTL
===============

# eth_tx_arb

Frame-level round-robin arbiter that shares the single MAC transmit byte stream between `N_PORTS` requesters. It sits between the requesters and the transmit side of `eth_mac`. It grants one requester per frame and passes that requester's bytes through with zero added latency. It aborts frames whose source stalls or restarts mid-frame, so the MAC is never left holding an open frame.

## Interface
- `N_PORTS`, default 2: number of requesters, 2..8.
- `STALL_MAX`, default 64: consecutive mid-frame cycles with source `s_vld` low before the frame is aborted, 1..1023.

- `clk_mac`  in  1  MAC clock; every register is clocked on its rising edge.
- `rst_n`  in  1  synchronous reset, active low.
- `s_vld`  in  N_PORTS  per-requester byte valid.
- `s_dat`  in  8*N_PORTS  per-requester byte; port i uses bits [8i+7:8i].
- `s_sof`  in  N_PORTS  first byte of frame.
- `s_eof`  in  N_PORTS  last byte of frame.
- `s_err`  in  N_PORTS  frame error; forwarded to the MAC.
- `s_ack`  out  N_PORTS  byte accepted from requester.
- `tx_vld`, `tx_dat[7:0]`, `tx_sof`, `tx_eof`, `tx_err`  out  MAC transmit stream.
- `tx_ack`  in  1  MAC accepts the byte. `tx_ack` never depends combinationally on `tx_vld`.
- `grant`  out  N_PORTS  one-hot current owner; all zero when the arbiter owns no frame.
- `drop_cnt`  out  16  saturating count of discarded bytes.

## Operation
- Transfer rule: a byte moves on a cycle where valid and ack are both high. This holds on both sides of the arbiter.
- States:
  - IDLE: no frame owned.
  - XFER: pass-through for the granted port.
  - ABORT: arbiter-generated error byte to the MAC.
  - DRAIN: discard the rest of the granted port's frame.
- IDLE:
  - Candidates are ports with `s_vld & s_sof`.
  - The winner is the first candidate scanning upward from `last+1`, wrapping modulo `N_PORTS`. `last` resets to `N_PORTS-1`, so port 0 has first priority after reset.
  - The winner is registered into `grant` and `last`, and the state moves to XFER.
  - A port with `s_vld` high and `s_sof` low is a stray byte. Ack it the same cycle, discard it, and increment `drop_cnt`.
  - No acks go to candidates while in IDLE.
- XFER, granted port g:
  - `tx_vld/dat/sof/eof/err` equal port g's inputs.
  - `s_ack[g] = tx_ack`.
  - All other `s_ack` bits are 0.
  - When the eof byte transfers, go to IDLE and clear `grant`.
- Stall:
  - The stall counter increments each XFER cycle where `s_vld[g]` is 0.
  - It clears on any cycle where `s_vld[g]` is 1.
  - When the counter reaches `STALL_MAX`, go to ABORT. The next state after ABORT is DRAIN.
- Restart: if `s_vld[g] & s_sof[g]` appears after the first byte of the frame:
  - Do not ack that byte.
  - Suppress `tx_vld` that cycle.
  - Go to ABORT. The next state after ABORT is IDLE, so the new frame is re-arbitrated.
- ABORT:
  - Drive `tx_vld=1`, `tx_dat=0`, `tx_eof=1`, `tx_err=1`, `tx_sof=0`.
  - Hold these until `tx_ack`, then take the recorded next state.
- DRAIN:
  - `s_ack[g]=1`.
  - Every byte is discarded and counted in `drop_cnt`.
  - Leave for IDLE when `s_vld[g] & s_eof[g]` transfers.
- An sof+eof single-byte frame is legal; XFER ends after that one byte.
- `drop_cnt` saturates at 16'hFFFF.

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE, `last = N_PORTS-1`, stall counter 0.
- Reset asserted mid-frame returns to IDLE on the next edge. The MAC sees `tx_vld` drop, with no eof.
- Arbitration latency: request seen in IDLE at cycle n; the first byte is presented to the MAC at cycle n+1.
- Minimum gap between consecutive frames is one IDLE cycle.
- Data path latency in XFER is 0 cycles (combinational mux on registered `grant`).
- Stall abort: ABORT is entered STALL_MAX cycles after the last valid cycle of the granted port.

## Structure
- Package `eth_pkg` holds:
  - the state encodings IDLE/XFER/ABORT/DRAIN;
  - `ETH_BYTE_W = 8`;
  - the `drop_cnt` width.
- Sub-module `eth_rr_pick` is combinational: request vector plus last-grant index in, one-hot winner out, parameterised by `N_PORTS`.

## Test plan
- Ports 0 and 1 both request at once after reset, with `tx_ack` always 1.
  - Port 0's frame (60 bytes) is sent first, then port 1's.
  - `grant` = 01, then 00 for one cycle, then 10.
- Three back-to-back frames from each of ports 0 and 1: grants alternate 0,1,0,1,0,1.
- Port 0 stops after byte 10 for 64 cycles.
  - Expect one byte with `tx_eof=1`, `tx_err=1`, `tx_dat=0`.
  - The remaining 20 bytes of the frame are acked and dropped; `drop_cnt`=20.
  - Port 1 is then granted.
- Port 1 raises sof at byte 5 of its frame.
  - The error byte is sent and the offending byte is not acked.
  - Port 1 is re-granted on the next arbitration with `tx_sof=1`.
- Stray byte on port 0 (vld without sof) while IDLE: acked the same cycle, no `tx_vld`, `drop_cnt`=1.
- `tx_ack` toggling 1,0,1,0 during a frame: the bytes reach the MAC in order, with no duplicates and no losses.

Source files
------------

// File: rtl/eth_pkg.sv
// eth_pkg: shared constants for the MAC transmit arbiter.
// FSM encodings, byte width, drop counter width, saturating add.
package eth_pkg;

  localparam int ETH_BYTE_W = 8;
  localparam int DROP_W     = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_XFER  = 2'd1;
  localparam logic [1:0] ST_ABORT = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  function automatic logic [DROP_W-1:0] drop_add(
    input logic [DROP_W-1:0] cnt,
    input logic [3:0]        n
  );
    logic [DROP_W:0] sum;
    sum = {1'b0, cnt} + {{(DROP_W-3){1'b0}}, n};
    return sum[DROP_W] ? '1 : sum[DROP_W-1:0];
  endfunction

endpackage

// File: rtl/eth_rr_pick.sv
// eth_rr_pick: combinational round-robin picker.
// req: request vector; last: previous winner index; pick: one-hot winner.
module eth_rr_pick #(
  parameter int N_PORTS = 2,
  parameter int IW      = $clog2(N_PORTS)
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [IW-1:0]      last,
  output logic [N_PORTS-1:0] pick
);

  logic [IW-1:0] idx;
  logic          found;

  // Scan upward from last+1, wrapping, first hit wins.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N_PORTS; k++) begin
      idx = IW'((int'(last) + k) % N_PORTS);
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/eth_tx_arb.sv
// eth_tx_arb: frame-level round-robin arbiter onto the MAC tx stream.
// s_*: requester streams; tx_*: MAC stream; grant: owner; drop_cnt: discards.
module eth_tx_arb
  import eth_pkg::*;
#(
  parameter int N_PORTS   = 2,
  parameter int STALL_MAX = 64
) (
  input  logic                         clk_mac,
  input  logic                         rst_n,
  input  logic [N_PORTS-1:0]           s_vld,
  input  logic [ETH_BYTE_W*N_PORTS-1:0] s_dat,
  input  logic [N_PORTS-1:0]           s_sof,
  input  logic [N_PORTS-1:0]           s_eof,
  input  logic [N_PORTS-1:0]           s_err,
  output logic [N_PORTS-1:0]           s_ack,
  output logic                         tx_vld,
  output logic [ETH_BYTE_W-1:0]        tx_dat,
  output logic                         tx_sof,
  output logic                         tx_eof,
  output logic                         tx_err,
  input  logic                         tx_ack,
  output logic [N_PORTS-1:0]           grant,
  output logic [DROP_W-1:0]            drop_cnt
);

  localparam int IW = $clog2(N_PORTS);
  localparam int SW = $clog2(STALL_MAX + 1);

  logic [1:0]            state;
  logic [IW-1:0]         last;
  logic [SW-1:0]         stall;
  logic                  started;
  logic                  ab_idle;

  logic [N_PORTS-1:0]    cand;
  logic [N_PORTS-1:0]    stray;
  logic [N_PORTS-1:0]    pick;
  logic [IW-1:0]         pick_idx;
  logic [3:0]            n_stray;
  logic [N_PORTS-1:0]    ack_raw;

  logic                  g_vld;
  logic                  g_sof;
  logic                  g_eof;
  logic                  g_err;
  logic [ETH_BYTE_W-1:0] g_dat;
  logic                  restart;

  assign cand  = s_vld & s_sof;
  assign stray = s_vld & ~s_sof;

  assign g_vld = |(s_vld & grant);
  assign g_sof = |(s_sof & grant);
  assign g_eof = |(s_eof & grant);
  assign g_err = |(s_err & grant);

  // New sof from the owner after its first byte moved.
  assign restart = g_vld & g_sof & started;

  eth_rr_pick #(
    .N_PORTS (N_PORTS),
    .IW      (IW)
  ) u_pick (
    .req  (cand),
    .last (last),
    .pick (pick)
  );

  always_comb begin
    g_dat = '0;
    for (int i = 0; i < N_PORTS; i++)
      if (grant[i])
        g_dat = s_dat[ETH_BYTE_W*i +: ETH_BYTE_W];
  end

  always_comb begin
    pick_idx = '0;
    n_stray  = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (pick[i])
        pick_idx = IW'(i);
      n_stray = n_stray + {3'b0, stray[i]};
    end
  end

  always_comb begin
    tx_vld  = 1'b0;
    tx_dat  = '0;
    tx_sof  = 1'b0;
    tx_eof  = 1'b0;
    tx_err  = 1'b0;
    ack_raw = '0;
    unique case (state)
      ST_IDLE: begin
        ack_raw = stray;
      end
      ST_XFER: begin
        tx_vld  = g_vld & ~restart;
        tx_dat  = g_dat;
        tx_sof  = g_sof;
        tx_eof  = g_eof;
        tx_err  = g_err;
        ack_raw = grant & {N_PORTS{tx_ack & ~restart}};
      end
      ST_ABORT: begin
        tx_vld = 1'b1;
        tx_eof = 1'b1;
        tx_err = 1'b1;
      end
      ST_DRAIN: begin
        ack_raw = grant;
      end
      default: ;
    endcase
  end

  // Nothing is consumed from a requester while reset is held.
  assign s_ack = ack_raw & {N_PORTS{rst_n}};

  always_ff @(posedge clk_mac) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      grant    <= '0;
      last     <= IW'(N_PORTS - 1);
      stall    <= '0;
      started  <= 1'b0;
      ab_idle  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          drop_cnt <= drop_add(drop_cnt, n_stray);
          if (|cand) begin
            grant   <= pick;
            last    <= pick_idx;
            state   <= ST_XFER;
            started <= 1'b0;
            stall   <= '0;
          end
        end
        ST_XFER: begin
          if (restart) begin
            state   <= ST_ABORT;
            ab_idle <= 1'b1;
          end else if (g_vld) begin
            stall <= '0;
            if (tx_ack) begin
              started <= 1'b1;
              if (g_eof) begin
                state <= ST_IDLE;
                grant <= '0;
              end
            end
          end else if (stall == SW'(STALL_MAX - 1)) begin
            stall   <= '0;
            state   <= ST_ABORT;
            ab_idle <= 1'b0;
          end else begin
            stall <= stall + SW'(1);
          end
        end
        ST_ABORT: begin
          if (tx_ack) begin
            if (ab_idle) begin
              state <= ST_IDLE;
              grant <= '0;
            end else begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (g_vld) begin
            drop_cnt <= drop_add(drop_cnt, 4'd1);
            if (g_eof) begin
              state <= ST_IDLE;
              grant <= '0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
